text_console_m: RTL and testbench

- Character-stream front end for the 80x60 text-mode VGA driver.
- Accepts one character per handshake from the CPU MMIO bridge and tracks a hardware cursor.
- Interprets control codes, clears rows on line advance, and clears the whole screen on command.
- Drives the driver's text-memory write port (byte enables, word address, data) directly.

---
 rtl/text_console_m_if.sv | 12 +
 rtl/text_console_m.sv | 175 +++++++++++++++++
 tb/tb_text_console_m.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/text_console_m_if.sv
// Character stream from the CPU MMIO bridge into the text console.
// The source holds i_char/i_fg/i_bg stable while i_valid is high and o_ready is low.
interface text_console_m_if;
  logic       i_valid;
  logic       o_ready;
  logic [7:0] i_char;
  logic [3:0] i_fg;
  logic [3:0] i_bg;

  modport master (output i_valid, i_char, i_fg, i_bg, input o_ready);
  modport slave  (input i_valid, i_char, i_fg, i_bg, output o_ready);
endinterface

// File: rtl/text_console_m.sv
// Text console front end: interprets a character stream, tracks the cursor and
// writes glyph cells / cleared rows / cleared screens into the VGA text memory.
module text_console_m #(
  parameter int COLS           = 80,
  parameter int ROWS           = 60,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  text_console_m_if.slave     cpu,
  output logic [3:0]          o_vga_mem_we,
  output logic [11:0]         o_vga_mem_waddr,
  output logic [31:0]         o_vga_mem_wdata,
  output logic [6:0]          o_cursor_col,
  output logic [5:0]          o_cursor_row
);

  localparam int          HALF         = COLS / 2;
  localparam logic [11:0] HALF_W       = 12'(HALF);
  localparam logic [11:0] ROW_LAST_CNT = 12'(HALF - 1);
  localparam logic [11:0] SCR_LAST_CNT = 12'(ROWS * HALF - 1);
  localparam logic [6:0]  LAST_COL     = 7'(COLS - 1);
  localparam logic [5:0]  LAST_ROW     = 6'(ROWS - 1);

  typedef enum logic [1:0] {IDLE, CLR_ROW, CLR_SCREEN} state_t;

  state_t      state_q, state_d;
  logic [6:0]  col_q, col_d;
  logic [5:0]  row_q, row_d;
  logic [11:0] cnt_q, cnt_d;
  logic [7:0]  attr_q, attr_d;
  logic [3:0]  we_q, we_d;
  logic [11:0] waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;

  logic        accept;
  logic [7:0]  attr_in;
  logic [5:0]  row_adv;
  logic [11:0] row_base;
  logic [6:0]  cell_col;
  logic [7:0]  cell_char;
  logic [15:0] cell_half;
  logic [31:0] fill_word;

  assign cpu.o_ready = (state_q == IDLE);
  assign accept      = cpu.i_valid && (state_q == IDLE);
  assign attr_in     = {cpu.i_bg, cpu.i_fg};
  assign row_adv     = (row_q == LAST_ROW) ? 6'd0 : row_q + 6'd1;
  assign row_base    = 12'(row_q) * HALF_W;

  // Backspace rewrites the cell left of the cursor with a space; glyphs use the cursor cell.
  assign cell_col  = (cpu.i_char == 8'h08) ? col_q - 7'd1 : col_q;
  assign cell_char = (cpu.i_char == 8'h08) ? 8'h20 : cpu.i_char;
  assign cell_half = {attr_in, cell_char};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fill
      assign fill_word[gi*16 +: 16] = {attr_q, 8'h20};
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= (CLEAR_ON_RESET != 0) ? CLR_SCREEN : IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          case (cpu.i_char)
            8'h0A:          state_d = CLR_ROW;
            8'h0C:          state_d = CLR_SCREEN;
            8'h0D, 8'h08:   state_d = IDLE;
            default:        if (col_q == LAST_COL) state_d = CLR_ROW;
          endcase
        end
      end
      CLR_ROW:    if (cnt_q == ROW_LAST_CNT) state_d = IDLE;
      CLR_SCREEN: if (cnt_q == SCR_LAST_CNT) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    we_d    = 4'h0;
    waddr_d = 12'h000;
    wdata_d = 32'h0;
    col_d   = col_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    attr_d  = attr_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          case (cpu.i_char)
            8'h0D: col_d = 7'd0;
            8'h0A: begin
              col_d  = 7'd0;
              row_d  = row_adv;
              attr_d = attr_in;
            end
            8'h0C: begin
              col_d  = 7'd0;
              row_d  = 6'd0;
              cnt_d  = 12'd0;
              attr_d = attr_in;
            end
            default: begin
              if (cpu.i_char != 8'h08 || col_q != 7'd0) begin
                we_d    = cell_col[0] ? 4'b0011 : 4'b1100;
                waddr_d = row_base + {6'd0, cell_col[6:1]};
                wdata_d = cell_col[0] ? {16'h0, cell_half} : {cell_half, 16'h0};
                if (cpu.i_char == 8'h08) begin
                  col_d = cell_col;
                end else if (col_q == LAST_COL) begin
                  col_d  = 7'd0;
                  row_d  = row_adv;
                  attr_d = attr_in;
                end else begin
                  col_d = col_q + 7'd1;
                end
              end
            end
          endcase
        end
      end
      CLR_ROW: begin
        we_d    = 4'hF;
        waddr_d = row_base + cnt_q;
        wdata_d = fill_word;
        cnt_d   = (cnt_q == ROW_LAST_CNT) ? 12'd0 : cnt_q + 12'd1;
      end
      CLR_SCREEN: begin
        we_d    = 4'hF;
        waddr_d = cnt_q;
        wdata_d = fill_word;
        cnt_d   = (cnt_q == SCR_LAST_CNT) ? 12'd0 : cnt_q + 12'd1;
      end
      default: ;
    endcase
  end

  // attr resets to light-grey-on-black so the power-up clear uses 0x07.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      col_q   <= 7'd0;
      row_q   <= 6'd0;
      cnt_q   <= 12'd0;
      attr_q  <= 8'h07;
      we_q    <= 4'h0;
      waddr_q <= 12'h000;
      wdata_q <= 32'h0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      attr_q  <= attr_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign o_vga_mem_we    = we_q;
  assign o_vga_mem_waddr = waddr_q;
  assign o_vga_mem_wdata = wdata_q;
  assign o_cursor_col    = col_q;
  assign o_cursor_row    = row_q;

endmodule

// File: tb/tb_text_console_m.sv
// Scoreboard bench for text_console_m: a cursor model queues expected writes per
// accepted character; a monitor pops and compares every write the DUT presents.
module tb_text_console_m;
  localparam int COLS = 80;
  localparam int ROWS = 60;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  mem_we;
  logic [11:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic [6:0]  cur_col;
  logic [5:0]  cur_row;

  text_console_m_if ifc ();

  text_console_m #(.COLS(COLS), .ROWS(ROWS), .CLEAR_ON_RESET(1)) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .cpu             (ifc),
    .o_vga_mem_we    (mem_we),
    .o_vga_mem_waddr (mem_waddr),
    .o_vga_mem_wdata (mem_wdata),
    .o_cursor_col    (cur_col),
    .o_cursor_row    (cur_row)
  );

  always #5 clk = ~clk;

  logic [47:0] sb_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int wr_count = 0;
  int m_col = 0;
  int m_row = 0;

  task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && mem_we != 4'h0) begin
      wr_count++;
      if (sb_q.size() == 0) begin
        chk("unexp_wr", {mem_we, mem_waddr, mem_wdata}, 48'h0);
      end else begin
        chk("mem_wr", {mem_we, mem_waddr, mem_wdata}, sb_q.pop_front());
      end
    end
  end

  task automatic push_wr(input logic [3:0] we, input int addr, input logic [31:0] data);
    sb_q.push_back({we, 12'(addr), data});
  endtask

  task automatic push_clear(input int first, input int count, input logic [7:0] a);
    for (int k = 0; k < count; k++) push_wr(4'hF, first + k, {a, 8'h20, a, 8'h20});
  endtask

  task automatic push_cell(input int col, input logic [7:0] a, input logic [7:0] c);
    if (col % 2 == 1) push_wr(4'b0011, m_row * (COLS/2) + col/2, {16'h0, a, c});
    else              push_wr(4'b1100, m_row * (COLS/2) + col/2, {a, c, 16'h0});
  endtask

  task automatic check_busy(input string tag, input int exp_busy);
    int n;
    n = 0;
    while (!ifc.o_ready && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    chk(tag, 48'(n), 48'(exp_busy));
    chk("cur_col", 48'(cur_col), 48'(m_col));
    chk("cur_row", 48'(cur_row), 48'(m_row));
  endtask

  task automatic send(input logic [7:0] c, input logic [3:0] fg, input logic [3:0] bg,
                      input bit wait_done);
    int n;
    int exp_busy;
    logic [7:0] a;
    a = {bg, fg};
    n = 0;
    while (!ifc.o_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (!ifc.o_ready) begin
      chk("rdy_timeout", 48'(ifc.o_ready), 48'h1);
      return;
    end
    exp_busy = 0;
    case (c)
      8'h0D: m_col = 0;
      8'h0A: begin
        m_col = 0;
        m_row = (m_row == ROWS-1) ? 0 : m_row + 1;
        push_clear(m_row * (COLS/2), COLS/2, a);
        exp_busy = COLS/2;
      end
      8'h08: begin
        if (m_col != 0) begin
          m_col--;
          push_cell(m_col, a, 8'h20);
        end
      end
      8'h0C: begin
        m_col = 0;
        m_row = 0;
        push_clear(0, ROWS * COLS/2, a);
        exp_busy = ROWS * COLS/2;
      end
      default: begin
        push_cell(m_col, a, c);
        if (m_col == COLS-1) begin
          m_col = 0;
          m_row = (m_row == ROWS-1) ? 0 : m_row + 1;
          push_clear(m_row * (COLS/2), COLS/2, a);
          exp_busy = COLS/2;
        end else begin
          m_col++;
        end
      end
    endcase
    ifc.i_valid = 1'b1;
    ifc.i_char  = c;
    ifc.i_fg    = fg;
    ifc.i_bg    = bg;
    @(posedge clk); #1;
    ifc.i_valid = 1'b0;
    ifc.i_char  = $urandom_range(0, 255);
    $display("tx char=%02h attr=%02h -> cursor (%0d,%0d)", c, a, m_col, m_row);
    if (wait_done) check_busy("busy_cycles", exp_busy);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sb_q.delete();
    repeat (2) @(negedge clk);
    chk("rst_we", 48'(mem_we), 48'h0);
    chk("rst_waddr", 48'(mem_waddr), 48'h0);
    chk("rst_wdata", 48'(mem_wdata), 48'h0);
    chk("rst_ready", 48'(ifc.o_ready), 48'h0);
    m_col = 0;
    m_row = 0;
    push_clear(0, ROWS * COLS/2, 8'h07);
    rst_n = 1'b1;
    $display("tx reset released, expecting full-screen clear");
    check_busy("reset_clear_cycles", ROWS * COLS/2);
  endtask

  initial begin
    int base;
    int n;
    ifc.i_valid = 1'b0;
    ifc.i_char  = 8'h00;
    ifc.i_fg    = 4'h0;
    ifc.i_bg    = 4'h0;

    do_reset();

    send(8'h41, 4'hF, 4'h1, 1);
    send(8'h42, 4'hF, 4'h1, 1);
    chk("col_after_AB", 48'(cur_col), 48'd2);

    send(8'h0D, 4'h7, 4'h0, 1);
    send(8'h08, 4'h7, 4'h0, 1);
    for (int i = 0; i < 5; i++) send(8'h30 + 8'(i), 4'hA, 4'h3, 1);
    send(8'h08, 4'h2, 4'h0, 1);
    send(8'h01, 4'h5, 4'h6, 1);

    send(8'h0D, 4'h7, 4'h0, 1);
    for (int i = 0; i < 5; i++) send(8'h0A, 4'h7, 4'h0, 1);
    for (int i = 0; i < 3; i++) send(8'h78, 4'hC, 4'h0, 1);
    send(8'h0A, 4'h7, 4'h0, 1);
    chk("row_after_LF", 48'(cur_row), 48'd6);

    while (m_row != ROWS-1) send(8'h0A, 4'h1, 4'h0, 1);
    for (int i = 0; i < COLS-1; i++) send(8'h61 + 8'(i % 26), 4'hE, 4'h4, 1);
    send(8'h7E, 4'h9, 4'h2, 1);
    chk("wrap_row", 48'(cur_row), 48'd0);

    send(8'h48, 4'h3, 4'h0, 1);
    send(8'h69, 4'h3, 4'h0, 1);
    base = wr_count;
    send(8'h0C, 4'h4, 4'h2, 0);
    n = 0;
    while (wr_count < base + 100 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("ff_progress", 48'(wr_count - base), 48'd100);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_we", 48'(mem_we), 48'h0);
    chk("abort_waddr", 48'(mem_waddr), 48'h0);
    chk("abort_wdata", 48'(mem_wdata), 48'h0);
    chk("abort_col", 48'(cur_col), 48'h0);
    do_reset();

    send(8'h5A, 4'hB, 4'h0, 1);
    repeat (3) @(negedge clk);
    chk("sb_empty", 48'(sb_q.size()), 48'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
